axi_cmd_splitter: RTL and testbench

AXI_CMD_SPLITTER -- requirements
Module: axi_cmd_splitter

---
 rtl/axi_cmd_splitter.sv | 180 ++++++++++++++++++
 tb/tb_axi_cmd_splitter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cmd_splitter.sv
// axi_cmd_splitter: splits a byte-addressed read/write request into AXI INCR
// bursts that respect a maximum beat count and 4 KB boundaries. It limits the
// number of bursts in flight, gathers one response per burst, and reports a
// sticky error code plus a burst count when the request completes.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/ready/addr/length/id  request channel
//   m_ax_id/addr/len/size/burst/valid/ready  AR or AW master channel
//   resp_valid/ready/code         one response per burst (B, or R with RLAST)
//   done_valid/ready/error/bursts   completion channel
module axi_cmd_splitter #(
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_DATA_WIDTH      = 256,
    parameter int unsigned C_ID_WIDTH        = 8,
    parameter int unsigned C_LEN_WIDTH       = 36,
    parameter int unsigned C_MAX_BEATS       = 256,
    parameter int unsigned C_MAX_OUTSTANDING = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [C_ADDR_WIDTH-1:0] req_addr,
    input  logic [C_LEN_WIDTH-1:0]  req_length,
    input  logic [C_ID_WIDTH-1:0]   req_id,
    output logic [C_ID_WIDTH-1:0]   m_ax_id,
    output logic [C_ADDR_WIDTH-1:0] m_ax_addr,
    output logic [7:0]              m_ax_len,
    output logic [2:0]              m_ax_size,
    output logic [1:0]              m_ax_burst,
    output logic                    m_ax_valid,
    input  logic                    m_ax_ready,
    input  logic                    resp_valid,
    output logic                    resp_ready,
    input  logic [1:0]              resp_code,
    output logic                    done_valid,
    input  logic                    done_ready,
    output logic [1:0]              done_error,
    output logic [15:0]             done_bursts
);

    localparam int unsigned BYTES = C_DATA_WIDTH / 8;
    localparam int unsigned SIZE  = $clog2(BYTES);
    // Beat counters hold ceil(length/BYTES) and must also hold 4 KB beat counts.
    localparam int unsigned BW    = (C_LEN_WIDTH + 1 > 13) ? C_LEN_WIDTH + 1 : 13;
    localparam int unsigned OW    = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                  state;
    logic [BW-1:0]           remaining;
    logic [8:0]              cur_beats;
    logic [OW-1:0]           outstanding;

    logic                    ax_hs;
    logic                    resp_hs;
    logic [OW-1:0]           out_next;
    logic [BW-1:0]           rem_next;
    logic [C_ADDR_WIDTH-1:0] addr_next;
    logic [8:0]              beats_next;
    logic                    can_issue;
    logic [C_ADDR_WIDTH-1:0] acc_addr;
    logic [BW-1:0]           acc_total;
    logic [8:0]              acc_first;

    // Burst size = min(remaining beats, max beats, beats left in this 4 KB page).
    function automatic logic [8:0] burst_beats(input logic [C_ADDR_WIDTH-1:0] a,
                                               input logic [BW-1:0] rem);
        logic [12:0]   to_4k;
        logic [BW-1:0] lim;
        to_4k = (13'd4096 - {1'b0, a[11:0]}) >> SIZE;
        lim   = rem;
        if (BW'(C_MAX_BEATS) < lim) lim = BW'(C_MAX_BEATS);
        if (BW'(to_4k) < lim) lim = BW'(to_4k);
        return 9'(lim);
    endfunction

    assign m_ax_size  = 3'(SIZE);
    assign m_ax_burst = 2'b01;

    // Next-cycle bookkeeping shared by the state register.
    always_comb begin
        ax_hs      = m_ax_valid & m_ax_ready;
        resp_hs    = resp_valid & resp_ready;
        out_next   = outstanding + OW'(ax_hs) - OW'(resp_hs);
        rem_next   = ax_hs ? remaining - BW'(cur_beats) : remaining;
        addr_next  = ax_hs ? m_ax_addr + (C_ADDR_WIDTH'(cur_beats) << SIZE) : m_ax_addr;
        beats_next = burst_beats(addr_next, rem_next);
        can_issue  = (rem_next != '0) && (out_next < OW'(C_MAX_OUTSTANDING));
        acc_addr   = req_addr & ~(C_ADDR_WIDTH'(BYTES - 1));
        acc_total  = (BW'(req_length) + BW'(BYTES - 1)) >> SIZE;
        acc_first  = burst_beats(acc_addr, acc_total);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= '0;
            cur_beats   <= '0;
            outstanding <= '0;
            req_ready   <= 1'b0;
            m_ax_id     <= '0;
            m_ax_addr   <= '0;
            m_ax_len    <= '0;
            m_ax_valid  <= 1'b0;
            resp_ready  <= 1'b0;
            done_valid  <= 1'b0;
            done_error  <= 2'b00;
            done_bursts <= '0;
        end else begin
            outstanding <= out_next;
            // First SLVERR/DECERR sticks; EXOKAY has bit 1 clear and counts as OKAY.
            if (resp_hs && resp_code[1] && !done_error[1]) done_error <= resp_code;

            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        m_ax_id     <= req_id;
                        m_ax_addr   <= acc_addr;
                        remaining   <= acc_total;
                        cur_beats   <= acc_first;
                        m_ax_len    <= 8'(acc_first - 9'd1);
                        done_error  <= 2'b00;
                        done_bursts <= '0;
                        if (acc_total == '0) begin
                            state      <= DONE;
                            done_valid <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            m_ax_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    m_ax_addr <= addr_next;
                    remaining <= rem_next;
                    cur_beats <= beats_next;
                    m_ax_len  <= 8'(beats_next - 9'd1);
                    if (ax_hs) done_bursts <= done_bursts + 16'd1;
                    if (rem_next == '0) begin
                        m_ax_valid <= 1'b0;
                        if (out_next == '0) begin
                            state      <= DONE;
                            done_valid <= 1'b1;
                            resp_ready <= 1'b0;
                        end else begin
                            state      <= DRAIN;
                            resp_ready <= 1'b1;
                        end
                    end else begin
                        // Valid only drops on a handshake, so held bursts stay stable.
                        m_ax_valid <= can_issue;
                        resp_ready <= (out_next != '0);
                    end
                end
                DRAIN: begin
                    if (out_next == '0) begin
                        state      <= DONE;
                        done_valid <= 1'b1;
                        resp_ready <= 1'b0;
                    end else begin
                        resp_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (done_ready) begin
                        state      <= IDLE;
                        done_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_cmd_splitter.sv
// tb_axi_cmd_splitter: directed, self-checking bench for axi_cmd_splitter with
// 256-bit data, 16-beat bursts and two outstanding bursts. Expected bursts are
// queued when a request is driven and popped as the DUT presents them.
module tb_axi_cmd_splitter;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [35:0] req_length;
    logic [7:0]  req_id;
    logic [7:0]  m_ax_id;
    logic [63:0] m_ax_addr;
    logic [7:0]  m_ax_len;
    logic [2:0]  m_ax_size;
    logic [1:0]  m_ax_burst;
    logic        m_ax_valid;
    logic        m_ax_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_code;
    logic        done_valid;
    logic        done_ready;
    logic [1:0]  done_error;
    logic [15:0] done_bursts;

    axi_cmd_splitter #(
        .C_ADDR_WIDTH(64), .C_DATA_WIDTH(256), .C_ID_WIDTH(8), .C_LEN_WIDTH(36),
        .C_MAX_BEATS(16), .C_MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_length(req_length), .req_id(req_id),
        .m_ax_id(m_ax_id), .m_ax_addr(m_ax_addr), .m_ax_len(m_ax_len),
        .m_ax_size(m_ax_size), .m_ax_burst(m_ax_burst), .m_ax_valid(m_ax_valid),
        .m_ax_ready(m_ax_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_code(resp_code),
        .done_valid(done_valid), .done_ready(done_ready), .done_error(done_error),
        .done_bursts(done_bursts)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } burst_t;

    burst_t     exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         pending = 0;
    int         resp_count = 0;
    int         ax_count = 0;
    int         cyc = 0;
    int         last_resp_cyc = -1;
    logic [7:0] cur_id = 8'h00;
    logic [1:0] ok_code = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] a, input logic [7:0] l);
        burst_t b;
        b.addr = a;
        b.len  = l;
        exp_q.push_back(b);
    endtask

    // Present one request at a negedge; it is accepted on the following posedge.
    task automatic drive_req(input logic [63:0] a, input logic [35:0] len, input logic [7:0] id);
        pending = 0; resp_count = 0; ax_count = 0; last_resp_cyc = -1; cur_id = id;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_addr = a; req_length = len; req_id = id;
        @(negedge clk);
        req_valid = 1'b0;
        check("req_ready_busy", 64'(req_ready), 64'd0);
    endtask

    // One clock of slave behaviour: answer an outstanding burst, accept/check an AX.
    task automatic step(input bit resp_en, input int err_idx, input bit stall);
        cyc++;
        m_ax_ready = 1'b0; resp_valid = 1'b0; resp_code = 2'b00;
        if (resp_en && resp_ready && pending > 0) begin
            resp_valid = 1'b1;
            resp_code  = (resp_count == err_idx) ? 2'b10 : ok_code;
            resp_count++; pending--; last_resp_cyc = cyc;
        end
        if (m_ax_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ax", 64'(m_ax_valid), 64'd0);
            end else begin
                check("ax_addr", m_ax_addr, exp_q[0].addr);
                check("ax_len", 64'(m_ax_len), 64'(exp_q[0].len));
                check("ax_size", 64'(m_ax_size), 64'd5);
                check("ax_burst", 64'(m_ax_burst), 64'd1);
                check("ax_id", 64'(m_ax_id), 64'(cur_id));
                if (!(stall && $urandom_range(0, 1) == 0)) begin
                    m_ax_ready = 1'b1;
                    void'(exp_q.pop_front());
                    pending++; ax_count++;
                end
            end
        end
        @(negedge clk);
        m_ax_ready = 1'b0; resp_valid = 1'b0;
    endtask

    task automatic release_done();
        check("done_hold", 64'(done_valid), 64'd1);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check("done_clear", 64'(done_valid), 64'd0);
        check("req_ready_back", 64'(req_ready), 64'd1);
    endtask

    task automatic run_until_done(input int err_idx, input bit stall,
                                  input logic [1:0] exp_err, input logic [15:0] exp_bursts);
        int n = 0;
        while (!done_valid && n < 300) begin
            step(1'b1, err_idx, stall);
            n++;
        end
        check("done_seen", 64'(done_valid), 64'd1);
        if (done_valid) begin
            check("done_latency", 64'(cyc), 64'(last_resp_cyc));
            check("done_error", 64'(done_error), 64'(exp_err));
            check("done_bursts", 64'(done_bursts), 64'(exp_bursts));
            check("queue_empty", 64'(exp_q.size()), 64'd0);
            check("resp_all", 64'(pending), 64'd0);
            @(negedge clk);
            release_done();
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_length = '0; req_id = '0;
        m_ax_ready = 1'b0; resp_valid = 1'b0; resp_code = 2'b00; done_ready = 1'b0;
        #12;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_ax_valid", 64'(m_ax_valid), 64'd0);
        check("rst_resp_ready", 64'(resp_ready), 64'd0);
        check("rst_done_valid", 64'(done_valid), 64'd0);
        check("rst_done_error", 64'(done_error), 64'd0);
        check("rst_done_bursts", 64'(done_bursts), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("req_ready_after_rst", 64'(req_ready), 64'd1);

        // Single burst inside one page.
        push(64'h1000, 8'd1);
        drive_req(64'h1000, 36'd64, 8'h11);
        check("first_ax_latency", 64'(m_ax_valid), 64'd1);
        run_until_done(-1, 1'b0, 2'b00, 16'd1);

        // 4 KB crossing splits the request.
        push(64'h0FE0, 8'd0);
        push(64'h1000, 8'd1);
        drive_req(64'h0FE0, 36'd96, 8'h22);
        run_until_done(-1, 1'b1, 2'b00, 16'd2);

        // Max-beat split; EXOKAY responses count as OKAY.
        ok_code = 2'b01;
        push(64'h0000, 8'd15);
        push(64'h0200, 8'd15);
        drive_req(64'h0, 36'd1024, 8'h33);
        run_until_done(-1, 1'b0, 2'b00, 16'd2);
        ok_code = 2'b00;

        // Zero length completes without any burst.
        drive_req(64'h1234, 36'd0, 8'h44);
        check("zero_no_ax", 64'(m_ax_valid), 64'd0);
        check("zero_done_valid", 64'(done_valid), 64'd1);
        check("zero_done_bursts", 64'(done_bursts), 64'd0);
        release_done();

        // Outstanding limit with responses withheld.
        push(64'h0000, 8'd15); push(64'h0200, 8'd15);
        push(64'h0400, 8'd15); push(64'h0600, 8'd15);
        drive_req(64'h0, 36'd2048, 8'h55);
        for (int i = 0; i < 6; i++) step(1'b0, -1, 1'b0);
        check("limit_ax_count", 64'(ax_count), 64'd2);
        check("limit_ax_low", 64'(m_ax_valid), 64'd0);
        step(1'b1, -1, 1'b0);
        check("limit_resume", 64'(m_ax_valid), 64'd1);
        run_until_done(-1, 1'b0, 2'b00, 16'd4);

        // SLVERR on the second response; all bursts still go out.
        push(64'h0040, 8'd15); push(64'h0240, 8'd15);
        push(64'h0440, 8'd15); push(64'h0640, 8'd15);
        drive_req(64'h0040, 36'd2048, 8'h66);
        run_until_done(1, 1'b1, 2'b10, 16'd4);

        // Reset in the middle of a request, with a late response afterwards.
        push(64'h0000, 8'd15); push(64'h0200, 8'd15);
        drive_req(64'h0, 36'd2048, 8'h77);
        step(1'b0, -1, 1'b0);
        step(1'b0, -1, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_ax_valid", 64'(m_ax_valid), 64'd0);
        check("midrst_resp_ready", 64'(resp_ready), 64'd0);
        check("midrst_done_bursts", 64'(done_bursts), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        resp_valid = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 64'(req_ready), 64'd1);
        check("post_rst_resp_ready", 64'(resp_ready), 64'd0);
        resp_valid = 1'b0;
        push(64'h1000, 8'd1);
        drive_req(64'h1000, 36'd64, 8'h88);
        run_until_done(-1, 1'b0, 2'b00, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
